// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and sizes for the video RAM read/write port arbiter
//   VRAM_AW / VRAM_DW : address and data width of the 32 KiB byte-wide video RAM
//   owner_e           : which requester owns an access (CPU or blitter)
//   arb_state_e       : arbiter ownership state
package vram_pkg;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_BLT = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_BLT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_rd_return.sv
// rtl/vram_rd_return.sv - owner-tagged read return pipe for the shared video RAM port
//   clk, rst_n             : clock, asynchronous active-low reset
//   rd_issue, rd_owner     : a read was accepted this edge, and by whom
//   ram_rdata              : registered RAM read data, valid the cycle after the address
//   cpu_rdata, cpu_rvalid  : CPU read return (rvalid is a one-cycle pulse)
//   blt_rdata, blt_rvalid  : blitter read return (rvalid is a one-cycle pulse)
module vram_rd_return
  import vram_pkg::*;
#(
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_issue,
  input  owner_e        rd_owner,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] blt_rdata,
  output logic          blt_rvalid
);

  // Stage 0 tags the cycle in which the RAM presents the data; stage 1 tags
  // the cycle in which the captured byte is presented to its owner.
  logic   tag_valid0, tag_valid1;
  owner_e tag_owner0, tag_owner1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid0 <= 1'b0;
      tag_valid1 <= 1'b0;
      tag_owner0 <= OWN_CPU;
      tag_owner1 <= OWN_CPU;
      cpu_rdata  <= '0;
      blt_rdata  <= '0;
    end else begin
      tag_valid0 <= rd_issue;
      tag_owner0 <= rd_owner;
      tag_valid1 <= tag_valid0;
      tag_owner1 <= tag_owner0;
      if (tag_valid0) begin
        if (tag_owner0 == OWN_CPU) cpu_rdata <= ram_rdata;
        else                       blt_rdata <= ram_rdata;
      end
    end
  end

  assign cpu_rvalid = tag_valid1 && (tag_owner1 == OWN_CPU);
  assign blt_rvalid = tag_valid1 && (tag_owner1 == OWN_BLT);

endmodule

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - CPU / blitter arbiter for the video RAM read/write port
//   clk, rst_n                                      : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_ack                  : CPU request and same-edge accept
//   cpu_rdata, cpu_rvalid                           : CPU read return, 2 cycles after accept
//   blt_req/we/addr/wdata/last, blt_ack             : blitter request, burst end, accept
//   blt_rdata, blt_rvalid                           : blitter read return
//   ram_addr, ram_wdata, ram_we, ram_rdata          : RAM read/write port
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int AW        = VRAM_AW,
  parameter int DW        = VRAM_DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          blt_req,
  input  logic          blt_we,
  input  logic [AW-1:0] blt_addr,
  input  logic [DW-1:0] blt_wdata,
  input  logic          blt_last,
  output logic          blt_ack,
  output logic [DW-1:0] blt_rdata,
  output logic          blt_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  // Count value at which a pending CPU request ends the blitter burst.
  localparam logic [7:0] BURST_END = 8'(MAX_BURST - 1);

  arb_state_e    state;
  owner_e        rr_last;
  logic [7:0]    burst_cnt;
  logic [AW-1:0] addr_q;
  logic          rd_issue;
  owner_e        rd_owner;

  // Grant decision. Acks are forced low under reset so that a requester
  // holding req through reset sees no accept and the RAM sees no write.
  always_comb begin
    cpu_ack = 1'b0;
    blt_ack = 1'b0;
    if (rst_n) begin
      if (state == ARB_BLT && blt_req) begin
        blt_ack = 1'b1;
      end else if (cpu_req && (!blt_req || rr_last == OWN_BLT)) begin
        cpu_ack = 1'b1;
      end else if (blt_req) begin
        blt_ack = 1'b1;
      end
    end
  end

  assign ram_we    = (cpu_ack && cpu_we) || (blt_ack && blt_we);
  assign ram_addr  = cpu_ack ? cpu_addr : (blt_ack ? blt_addr : addr_q);
  assign ram_wdata = cpu_ack ? cpu_wdata : blt_wdata;

  assign rd_issue = (cpu_ack && !cpu_we) || (blt_ack && !blt_we);
  assign rd_owner = cpu_ack ? OWN_CPU : OWN_BLT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      rr_last   <= OWN_BLT;
      burst_cnt <= '0;
      addr_q    <= '0;
    end else if (cpu_ack) begin
      state     <= ARB_CPU;
      rr_last   <= OWN_CPU;
      burst_cnt <= '0;
      addr_q    <= cpu_addr;
    end else if (blt_ack) begin
      rr_last <= OWN_BLT;
      addr_q  <= blt_addr;
      if (blt_last || (cpu_req && burst_cnt == BURST_END)) begin
        state     <= ARB_IDLE;
        burst_cnt <= '0;
      end else begin
        state <= ARB_BLT;
        // Saturating: once a CPU request appears the very next beat ends the burst.
        if (burst_cnt != BURST_END) burst_cnt <= burst_cnt + 8'd1;
      end
    end else begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
    end
  end

  vram_rd_return #(
    .DW(DW)
  ) u_rd_return (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_issue  (rd_issue),
    .rd_owner  (rd_owner),
    .ram_rdata (ram_rdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .blt_rdata (blt_rdata),
    .blt_rvalid(blt_rvalid)
  );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - scoreboard bench for the video RAM port arbiter
module tb_vram_port_arbiter;
  import vram_pkg::*;

  localparam int AW        = VRAM_AW;
  localparam int DW        = VRAM_DW;
  localparam int MAX_BURST = 16;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          blt_req, blt_we, blt_last, blt_ack, blt_rvalid;
  logic [AW-1:0] blt_addr;
  logic [DW-1:0] blt_wdata, blt_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;

  vram_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .blt_req(blt_req), .blt_we(blt_we), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_last(blt_last), .blt_ack(blt_ack), .blt_rdata(blt_rdata), .blt_rvalid(blt_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM with registered read data.
  logic [DW-1:0] ram_mem [0:32767];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    bit blt;
    bit we;
    int addr;
    int data;
    int edge_no;
  } xfer_t;

  typedef struct {
    int data;
    int due;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference state: every transfer is recorded at the edge it happens; the
  // model memory is updated by writes and supplies the expected read bytes.
  logic [DW-1:0] model_mem [0:32767];
  xfer_t log_q[$];
  exp_t  cpu_q[$];
  exp_t  blt_q[$];
  int    cyc = 0;
  int    blt_count = 0;
  int    cpu_rv_count = 0;
  bit    pend_v = 1'b0;
  xfer_t pend;
  exp_t  ex;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      cyc++;
      if (pend_v && rst_n) begin
        pend.edge_no = cyc;
        log_q.push_back(pend);
        if (pend.blt) blt_count++;
        if (pend.we) begin
          model_mem[pend.addr] = pend.data[7:0];
        end else begin
          ex.data = int'(model_mem[pend.addr]);
          ex.due  = cyc + 1;
          if (pend.blt) blt_q.push_back(ex);
          else          cpu_q.push_back(ex);
        end
      end
    end else if (!rst_n) begin
      pend_v = 1'b0;
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_blt_ack", 32'(blt_ack), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_blt_rvalid", 32'(blt_rvalid), 32'd0);
      cpu_q.delete();
      blt_q.delete();
    end else begin
      if (cpu_rvalid) begin
        cpu_rv_count++;
        if (cpu_q.size() == 0) note_fail("cpu_rvalid_unexpected", 1, 0);
        else begin
          ex = cpu_q.pop_front();
          check("cpu_rdata", 32'(cpu_rdata), 32'(ex.data));
          check("cpu_rvalid_cycle", 32'(cyc), 32'(ex.due));
        end
      end
      while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
        ex = cpu_q.pop_front();
        note_fail("cpu_rvalid_missing", cyc, ex.due);
      end
      if (blt_rvalid) begin
        if (blt_q.size() == 0) note_fail("blt_rvalid_unexpected", 1, 0);
        else begin
          ex = blt_q.pop_front();
          check("blt_rdata", 32'(blt_rdata), 32'(ex.data));
          check("blt_rvalid_cycle", 32'(cyc), 32'(ex.due));
        end
      end
      while (blt_q.size() > 0 && blt_q[0].due < cyc) begin
        ex = blt_q.pop_front();
        note_fail("blt_rvalid_missing", cyc, ex.due);
      end

      pend_v = 1'b0;
      if (cpu_ack && blt_ack) note_fail("both_acks", 2, 1);
      if (cpu_ack) begin
        check("cpu_ack_has_req", 32'(cpu_req), 32'd1);
        check("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
        check("ram_we_cpu", 32'(ram_we), 32'(cpu_we));
        if (cpu_we) check("ram_wdata_cpu", 32'(ram_wdata), 32'(cpu_wdata));
        pend_v = cpu_req;
        pend = '{blt: 1'b0, we: cpu_we, addr: int'(cpu_addr), data: int'(cpu_wdata), edge_no: 0};
      end else if (blt_ack) begin
        check("blt_ack_has_req", 32'(blt_req), 32'd1);
        check("ram_addr_blt", 32'(ram_addr), 32'(blt_addr));
        check("ram_we_blt", 32'(ram_we), 32'(blt_we));
        if (blt_we) check("ram_wdata_blt", 32'(ram_wdata), 32'(blt_wdata));
        pend_v = blt_req;
        pend = '{blt: 1'b1, we: blt_we, addr: int'(blt_addr), data: int'(blt_wdata), edge_no: 0};
      end else begin
        check("ram_we_idle", 32'(ram_we), 32'd0);
      end
    end
  end

  // Requester drivers: called just after a rising edge, return just after the
  // rising edge at which the access was accepted.
  task automatic cpu_op(input bit we, input int addr, input int data, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = DW'(data); cpu_req = 1'b1;
    while (!got && waited < 300) begin
      @(negedge clk);
      waited++;
      got = cpu_ack;
    end
    if (!got) note_fail("cpu_ack_timeout", waited, 300);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic blt_op(input bit we, input int addr, input int data, input bit last);
    bit got;
    int waited;
    got = 1'b0;
    waited = 0;
    blt_we = we; blt_addr = AW'(addr); blt_wdata = DW'(data); blt_last = last; blt_req = 1'b1;
    while (!got && waited < 300) begin
      @(negedge clk);
      waited++;
      got = blt_ack;
    end
    if (!got) note_fail("blt_ack_timeout", waited, 300);
    @(posedge clk);
    #1;
    blt_req = 1'b0;
    blt_last = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base, k, w, w3, rv_before, nblt;

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    blt_req = 1'b0; blt_we = 1'b0; blt_addr = '0; blt_wdata = '0; blt_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with both requesting; first grant after release goes to the CPU.
    base = log_q.size();
    fork
      begin cpu_op(1'b1, 'h0010, 'h11, w); end
      begin blt_op(1'b1, 'h0011, 'h22, 1'b1); end
      begin repeat (4) @(posedge clk); #1; rst_n = 1'b1; end
    join
    check("t1_xfer_count", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      check("t1_first_grant_cpu", 32'(log_q[base].blt), 32'd0);
      check("t1_second_grant_blt", 32'(log_q[base+1].blt), 32'd1);
    end

    // CPU write then read of the top address on consecutive edges.
    base = log_q.size();
    cpu_op(1'b1, 'h7FFF, 'hA5, w);
    cpu_op(1'b0, 'h7FFF, 0, w);
    if (log_q.size() >= base + 2)
      check("t2_back_to_back", 32'(log_q[base+1].edge_no), 32'(log_q[base].edge_no + 1));
    else note_fail("t2_xfer_count", log_q.size() - base, 2);
    repeat (4) @(posedge clk);
    #1;

    // 40-beat blitter burst, CPU raised after beat 3.
    base = log_q.size();
    nblt = blt_count;
    w3 = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) blt_op(1'b1, 'h1000 + i, (i * 7) ^ 'h5A, i == 39);
      end
      begin
        for (int i = 0; i < 300 && blt_count < nblt + 3; i++) begin @(posedge clk); #1; end
        cpu_op(1'b1, 'h1100, 'h77, w3);
      end
    join
    k = -1;
    for (int i = base; i < log_q.size(); i++) if (!log_q[i].blt && k < 0) k = i;
    check("t3_cpu_wait_bound", 32'(w3 <= MAX_BURST + 1), 32'd1);
    check("t3_blt_total", 32'(blt_count - nblt), 32'd40);
    if (k < base + 1 || k + 1 >= log_q.size()) note_fail("t3_cpu_xfer_position", k - base, 16);
    else begin
      check("t3_beats_before_cpu", 32'(k - base), 32'd16);
      check("t3_addr_before_cpu", 32'(log_q[k-1].addr), 32'h100F);
      check("t3_cpu_next_edge", 32'(log_q[k].edge_no), 32'(log_q[k-1].edge_no + 1));
      check("t3_resume_is_blt", 32'(log_q[k+1].blt), 32'd1);
      check("t3_resume_addr", 32'(log_q[k+1].addr), 32'h1010);
    end

    // Interleaved single-beat reads from both sides.
    cpu_op(1'b1, 'h0000, 'h3C, w);
    blt_op(1'b1, 'h0001, 'hC3, 1'b1);
    base = log_q.size();
    fork
      begin for (int i = 0; i < 8; i++) cpu_op(1'b0, 'h0000, 0, w); end
      begin for (int i = 0; i < 8; i++) blt_op(1'b0, 'h0001, 0, 1'b1); end
    join
    check("t4_xfer_count", 32'(log_q.size() - base), 32'd16);
    for (int i = base + 1; i < log_q.size(); i++)
      check("t4_alternate", 32'(log_q[i].blt != log_q[i-1].blt), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Cancelled blitter pulse while the CPU wins the port.
    blt_op(1'b1, 'h0300, 'h11, 1'b1);
    nblt = blt_count;
    fork
      begin
        blt_we = 1'b1; blt_addr = AW'('h0300); blt_wdata = 8'hEE; blt_req = 1'b1;
        @(posedge clk);
        #1;
        blt_req = 1'b0;
      end
      begin cpu_op(1'b1, 'h0301, 'h44, w); end
    join
    check("t5_no_blt_ack", 32'(blt_count - nblt), 32'd0);
    cpu_op(1'b0, 'h0300, 0, w);
    repeat (4) @(posedge clk);
    #1;

    // Reset one cycle after a CPU read is accepted, with a write pending.
    cpu_op(1'b1, 'h0400, 'h12, w);
    cpu_op(1'b0, 'h7FFF, 0, w);
    rv_before = cpu_rv_count;
    cpu_we = 1'b1; cpu_addr = AW'('h0400); cpu_wdata = 8'h99; cpu_req = 1'b1;
    #2;
    check("t6_we_before_reset", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_we_async_drop", 32'(ram_we), 32'd0);
    check("t6_ack_in_reset", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_rvalid", 32'(cpu_rv_count), 32'(rv_before));
    cpu_op(1'b0, 'h0400, 0, w);

    // Randomized traffic over a preloaded window.
    for (int i = 0; i < 64; i++) blt_op(1'b1, 'h2000 + i, $urandom_range(0, 255), i == 63);
    fork
      begin
        int wc, g;
        for (int i = 0; i < 150; i++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          cpu_op(bit'($urandom_range(0, 1)), 'h2000 + $urandom_range(0, 63),
                 $urandom_range(0, 255), wc);
          check("rand_cpu_wait_bound", 32'(wc <= MAX_BURST + 1), 32'd1);
        end
      end
      begin
        int len, g;
        bit dl;
        for (int b = 0; b < 40; b++) begin
          len = $urandom_range(1, 24);
          dl  = bit'($urandom_range(0, 1));
          for (int j = 0; j < len; j++)
            blt_op(bit'($urandom_range(0, 1)), 'h2000 + $urandom_range(0, 63),
                   $urandom_range(0, 255), dl && (j == len - 1));
          g = $urandom_range(0, 4);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
        end
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("final_cpu_queue_empty", 32'(cpu_q.size()), 32'd0);
    check("final_blt_queue_empty", 32'(blt_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
